// File: rtl/cu_sequencer_if.sv
// Sequencer <-> decoder/datapath bundle. Signal names match the legacy flat ports.
interface cu_sequencer_if #(
  parameter int unsigned CUL = 36
);
  logic                 run;
  logic [31:0]          IR;
  logic [3:0]           status;
  logic [4*(CUL+1)-1:0] dec_cw;
  logic [11:0]          dec_ns;
  logic [11:0]          dec_kmux;
  logic [3:0]           state;
  logic [CUL:0]         controlWord;
  logic [2:0]           k_mux;
  logic                 fetch;
  logic                 halted;
  logic                 fault;
  logic [15:0]          instr_count;

  modport master (
    input  run, IR, status, dec_cw, dec_ns, dec_kmux,
    output state, controlWord, k_mux, fetch, halted, fault, instr_count
  );

  modport slave (
    output run, IR, status, dec_cw, dec_ns, dec_kmux,
    input  state, controlWord, k_mux, fetch, halted, fault, instr_count
  );
endinterface

// File: rtl/cu_sequencer.sv
// Control-unit sequencer: FETCH/EXEC/HALT phases, decoder select by IR class,
// multi-cycle stepping via decoder next-state, watchdog on runaway instructions.
module cu_sequencer #(
  parameter int unsigned  CUL       = 36,
  parameter logic [CUL:0] FETCH_CW  = 37'h0_0000_0427,
  parameter logic [31:0]  HALT_WORD = 32'hFFFF_FFFF,
  parameter int unsigned  MAX_STEPS = 8
) (
  input logic           clock,
  input logic           reset,
  cu_sequencer_if.master bus
);
  typedef enum logic [1:0] {PH_FETCH, PH_EXEC, PH_HALT} phase_t;

  phase_t       phase_q, phase_d;
  logic [3:0]   state_q, state_d;
  logic [3:0]   steps_q, steps_d;
  logic [15:0]  count_q;
  logic         fault_q, fault_d;
  logic         retire;
  logic [1:0]   cls;
  logic [CUL:0] sel_cw;
  logic [2:0]   sel_ns;
  logic [2:0]   sel_kmux;
  logic [CUL:0] cw;
  logic [2:0]   kmux;
  logic         unused_status;

  assign cls      = bus.IR[1:0];
  assign sel_cw   = bus.dec_cw[int'(cls)*(CUL+1) +: CUL+1];
  assign sel_ns   = bus.dec_ns[int'(cls)*3 +: 3];
  assign sel_kmux = bus.dec_kmux[int'(cls)*3 +: 3];
  assign unused_status = ^bus.status;

  always_comb begin
    phase_d = phase_q;
    state_d = state_q;
    steps_d = steps_q;
    fault_d = fault_q;
    retire  = 1'b0;
    cw      = '0;
    kmux    = '0;
    unique case (phase_q)
      PH_FETCH: begin
        if (bus.run) begin
          cw      = FETCH_CW;
          phase_d = PH_EXEC;
          state_d = '0;
          steps_d = '0;
        end
      end
      PH_EXEC: begin
        if (steps_q == 4'd0 && bus.IR == HALT_WORD) begin
          phase_d = PH_HALT;
        end else begin
          cw   = sel_cw;
          kmux = sel_kmux;
          if (sel_ns == 3'd0) begin
            retire  = 1'b1;
            phase_d = PH_FETCH;
            state_d = '0;
          end else if (steps_q == 4'(MAX_STEPS - 1)) begin
            // Runaway instruction: this cycle's word still goes out, then trap.
            phase_d = PH_HALT;
            fault_d = 1'b1;
            state_d = '0;
          end else begin
            state_d = {1'b0, sel_ns};
            steps_d = steps_q + 4'd1;
          end
        end
      end
      PH_HALT: begin
        phase_d = PH_HALT;
      end
      default: begin
        phase_d = PH_FETCH;
        state_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q <= PH_FETCH;
      state_q <= '0;
      steps_q <= '0;
      fault_q <= 1'b0;
      count_q <= '0;
    end else begin
      phase_q <= phase_d;
      state_q <= state_d;
      steps_q <= steps_d;
      fault_q <= fault_d;
      if (retire) count_q <= count_q + 16'd1;
    end
  end

  assign bus.state       = state_q;
  assign bus.controlWord = cw;
  assign bus.k_mux       = kmux;
  assign bus.fetch       = (phase_q == PH_FETCH);
  assign bus.halted      = (phase_q == PH_HALT);
  assign bus.fault       = fault_q;
  assign bus.instr_count = count_q;
endmodule
